// File: rtl/hit_responder.sv
// hit_responder: per-player bullet hit detection, health, invulnerability, flash and game-over (optional HIT_REGEN_EN health regeneration)
module hit_responder #(
  parameter int MAX_HEALTH    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_PERIOD  = 8,
  parameter int REGEN_FRAMES  = 300
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       game_restart,
  input  logic       bullet_on,
  input  logic [9:0] BulletX,
  input  logic [9:0] BulletY,
  input  logic [9:0] BulletS,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] PlayerS,
  output logic       player_hit,
  output logic [2:0] health,
  output logic       invuln,
  output logic       flash,
  output logic       game_over
);
  localparam int FB = $clog2(BLINK_PERIOD);
  localparam int CW = $clog2(INVULN_FRAMES + 2 * BLINK_PERIOD);
  localparam logic [2:0] HMAX = 3'(MAX_HEALTH);
  if (MAX_HEALTH < 1 || MAX_HEALTH > 7 || INVULN_FRAMES < 1 || REGEN_FRAMES < 1 ||
      BLINK_PERIOD < 1 || (BLINK_PERIOD & (BLINK_PERIOD - 1)) != 0) begin : g_bad_params
    $error("hit_responder: illegal parameter value");
  end
  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;
  state_t state_q, state_d;
  logic [2:0] health_q, health_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic armed_q, armed_d, hit_q, hit_d;
  logic [10:0] dx, dy, sum;
  logic overlap, hit_now;
`ifdef HIT_REGEN_EN
  localparam int RW = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
  logic [RW-1:0] regen_q, regen_d;
`endif
  assign dx = (BulletX >= PlayerX) ? {1'b0, BulletX - PlayerX} : {1'b0, PlayerX - BulletX};
  assign dy = (BulletY >= PlayerY) ? {1'b0, BulletY - PlayerY} : {1'b0, PlayerY - BulletY};
  assign sum = {1'b0, BulletS} + {1'b0, PlayerS};
  assign overlap = bullet_on && dx < sum && dy < sum;
  assign hit_now = overlap && armed_q && state_q != DEAD;
  assign player_hit = hit_q;
  assign health = health_q;
  assign invuln = state_q == INVULN;
  assign game_over = state_q == DEAD;
  assign flash = invuln & cnt_q[FB];
  // next state: damage/absorb on hits, invulnerability countdown, regen, restart override
  always_comb begin
    state_d = state_q;
    health_d = health_q;
    cnt_d = cnt_q;
    hit_d = hit_now;
    armed_d = !bullet_on ? 1'b1 : hit_now ? 1'b0 : armed_q;
    if (state_q == ALIVE && hit_now) begin
      state_d = (health_q == 3'd1) ? DEAD : INVULN;
      health_d = health_q - 3'd1;
      cnt_d = CW'(INVULN_FRAMES - 1);
    end else if (state_q == INVULN) begin
      state_d = (cnt_q == '0) ? ALIVE : INVULN;
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    end
`ifdef HIT_REGEN_EN
    regen_d = '0;
    if (state_q == ALIVE && !hit_now && health_q < HMAX) begin
      regen_d = (regen_q == RW'(REGEN_FRAMES - 1)) ? '0 : regen_q + RW'(1);
      health_d = (regen_q == RW'(REGEN_FRAMES - 1)) ? health_q + 3'd1 : health_q;
    end
`endif
    if (game_restart) begin
      state_d = ALIVE;
      health_d = HMAX;
      cnt_d = '0;
      hit_d = 1'b0;
      armed_d = 1'b1;
`ifdef HIT_REGEN_EN
      regen_d = '0;
`endif
    end
  end
  // state registers with asynchronous reset
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ALIVE;
      health_q <= HMAX;
      cnt_q <= '0;
      armed_q <= 1'b1;
      hit_q <= 1'b0;
`ifdef HIT_REGEN_EN
      regen_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      health_q <= health_d;
      cnt_q <= cnt_d;
      armed_q <= armed_d;
      hit_q <= hit_d;
`ifdef HIT_REGEN_EN
      regen_q <= regen_d;
`endif
    end
  end
endmodule

// File: tb/tb_hit_responder.sv
// tb_hit_responder: directed self-checking bench for hit_responder
module tb_hit_responder;
  logic frame_clk = 1'b0;
  logic Reset_n = 1'b0;
  logic game_restart = 1'b0;
  logic bullet_on = 1'b0;
  logic [9:0] BulletX = '0, BulletY = '0, BulletS = '0;
  logic [9:0] PlayerX = 10'd320, PlayerY = 10'd240, PlayerS = 10'd4;
  logic player_hit, invuln, flash, game_over;
  logic [2:0] health;
  int checks = 0;
  int errors = 0;
  int pulses;

  hit_responder dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .game_restart(game_restart),
    .bullet_on(bullet_on), .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS),
    .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerS(PlayerS),
    .player_hit(player_hit), .health(health), .invuln(invuln), .flash(flash),
    .game_over(game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic bullet(input logic on, input int x, input int y, input int s);
    bullet_on = on;
    BulletX = 10'(x);
    BulletY = 10'(y);
    BulletS = 10'(s);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    bullet_on = 1'b0;
    game_restart = 1'b0;
    #12;
    Reset_n = 1'b1;
    step();
  endtask

  task automatic fresh_hit();
    bullet(1'b0, 326, 240, 4);
    step();
    bullet(1'b1, 326, 240, 4);
    step();
  endtask

  initial begin
    do_reset();
    check("rst_hit", player_hit, 0);
    check("rst_health", health, 3);
    check("rst_invuln", invuln, 0);
    check("rst_flash", flash, 0);
    check("rst_over", game_over, 0);

    bullet(1'b1, 326, 240, 4);
    step();
    check("hit1_pulse", player_hit, 1);
    check("hit1_health", health, 2);
    check("hit1_invuln", invuln, 1);
    check("hit1_flash", flash, 1);
    pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 9) bullet_on = 1'b0;
      if (i == 10) bullet_on = 1'b1;
      step();
      pulses += int'(player_hit);
      check("flash_seq", flash, (i < 60) ? ((59 - i) >> 3) & 1 : 0);
      if (i == 10) check("absorb_pulse", player_hit, 1);
      if (i == 10) check("absorb_health", health, 2);
      if (i == 59) check("invuln_last", invuln, 1);
    end
    check("invuln_end", invuln, 0);
    check("invuln_pulses", pulses, 1);
    check("invuln_health", health, 2);
    bullet_on = 1'b0;
    step();
    bullet_on = 1'b1;
    step();
    check("hit2_pulse", player_hit, 1);
    check("hit2_health", health, 1);

    do_reset();
    bullet(1'b1, 328, 240, 4);
    step();
    step();
    check("touch_x_pulse", player_hit, 0);
    check("touch_x_health", health, 3);
    bullet(1'b1, 320, 248, 4);
    step();
    check("touch_y_pulse", player_hit, 0);
    bullet(1'b0, 326, 240, 4);
    step();
    check("off_pulse", player_hit, 0);
    bullet(1'b1, 327, 243, 4);
    step();
    check("diag_pulse", player_hit, 1);
    check("diag_health", health, 2);
    do_reset();
    bullet(1'b1, 313, 240, 4);
    step();
    check("left_pulse", player_hit, 1);
    do_reset();
    bullet(1'b1, 312, 240, 4);
    step();
    check("left_touch", player_hit, 0);
    do_reset();
    PlayerS = 10'd1023;
    bullet(1'b1, 5, 240, 4);
    step();
    check("wide_sum", player_hit, 1);
    PlayerS = 10'd4;

    do_reset();
    fresh_hit();
    check("d1_health", health, 2);
    repeat (70) step();
    fresh_hit();
    check("d2_health", health, 1);
    repeat (70) step();
    fresh_hit();
    check("d3_pulse", player_hit, 1);
    check("d3_health", health, 0);
    check("d3_over", game_over, 1);
    check("d3_invuln", invuln, 0);
    fresh_hit();
    check("dead_pulse", player_hit, 0);
    check("dead_health", health, 0);
    game_restart = 1'b1;
    step();
    game_restart = 1'b0;
    check("restart_health", health, 3);
    check("restart_over", game_over, 0);
    bullet_on = 1'b0;
    step();
    bullet(1'b1, 326, 240, 4);
    game_restart = 1'b1;
    step();
    game_restart = 1'b0;
    check("restart_wins", player_hit, 0);
    check("restart_wins_hp", health, 3);
    step();
    check("post_restart_hit", player_hit, 1);
    check("post_restart_hp", health, 2);

    do_reset();
    fresh_hit();
    check("pre_async_hit", player_hit, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_hit", player_hit, 0);
    check("async_health", health, 3);
    check("async_invuln", invuln, 0);
    check("async_flash", flash, 0);
    check("async_over", game_over, 0);
    bullet_on = 1'b0;
    #2;
    Reset_n = 1'b1;
    step();

    fresh_hit();
    bullet_on = 1'b0;
    repeat (359) step();
    check("regen_before", health, 2);
    step();
`ifdef HIT_REGEN_EN
    check("regen_after", health, 3);
`else
    check("no_regen", health, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hit_responder.md
Name: hit_responder

Overview:
- Target-side counterpart to the player bullet objects. One instance sits on each player.
- Each frame it decides whether the opponent's live bullet overlaps the player's box. On a hit it returns a one-frame player_hit pulse to the firing bullet module, which uses it to despawn the bullet.
- It also tracks player health, an invulnerability window after each hit, the blink (flash) indication during that window, and game-over.
- Drives health and game-over to the HUD and game-state logic.

Parameters:
- MAX_HEALTH, 3, health value after reset or restart; legal range 1..7.
- INVULN_FRAMES, 60, number of frames of invulnerability after a damaging hit; must be at least 1.
- BLINK_PERIOD, 8, frames per half-period of flash; must be a power of 2.
- REGEN_FRAMES, 300, frames without a hit before +1 health; used only when HIT_REGEN_EN is defined.

Ports:
- frame_clk  in  1  frame clock (one edge per video frame)
- Reset_n  in  1  asynchronous, active-low reset
- game_restart  in  1  synchronous restart, sampled each frame
- bullet_on  in  1  opponent bullet is live
- BulletX  in  10  opponent bullet centre X
- BulletY  in  10  opponent bullet centre Y
- BulletS  in  10  opponent bullet half-size
- PlayerX  in  10  this player's centre X
- PlayerY  in  10  this player's centre Y
- PlayerS  in  10  this player's half-size
- player_hit  out  1  one-frame pulse to the opponent's bullet module
- health  out  3  remaining health
- invuln  out  1  high while in INVULN
- flash  out  1  sprite blink enable
- game_over  out  1  high while in DEAD

Behaviour:
- Reset (Reset_n low), applied asynchronously:
  - state = ALIVE, health = MAX_HEALTH, armed = 1.
  - player_hit = 0, invuln = 0, flash = 0, game_over = 0.
  - Invulnerability counter = 0, regen counter = 0.
- Overlap (combinational):
  - dx = |BulletX - PlayerX| and dy = |BulletY - PlayerY|, each computed at 11 bits with no wrap.
  - Half-size sums BulletS + PlayerS are computed at 11 bits.
  - overlap = bullet_on & (dx < sum) & (dy < sum). Both comparisons are strict, so boxes that only touch do not hit.
- armed flag (one hit per bullet flight):
  - Cleared on any cycle that asserts player_hit.
  - Set on any edge where bullet_on == 0.
- hit_now = overlap & armed & (state != DEAD).
- All outputs are registered. A hit detected on frame edge k makes player_hit = 1 for exactly edge k through edge k+1, then it returns to 0.
- State machine:
  - ALIVE, on hit_now:
    - If health == 1: health <= 0, go to DEAD, game_over <= 1.
    - Otherwise: health <= health - 1, go to INVULN, counter <= INVULN_FRAMES - 1, invuln <= 1.
  - INVULN:
    - hit_now still pulses player_hit (the bullet is absorbed) but health is unchanged.
    - counter decrements each frame. When counter == 0 on an edge, go to ALIVE and invuln <= 0.
  - DEAD: no player_hit pulses. The only exits are game_restart or Reset_n.
- flash = invuln & counter[log2(BLINK_PERIOD)]. flash is 0 outside INVULN.
- game_restart = 1 from any state:
  - Same values as reset, applied at the edge.
  - Restart wins over a simultaneous hit_now.
- Reset_n asserted mid-INVULN or mid-pulse aborts immediately to reset values.
- health never underflows below 0 and never exceeds MAX_HEALTH.

Optional Feature:
- Macro: HIT_REGEN_EN.
- When defined:
  - A regen counter increments each frame in ALIVE while health < MAX_HEALTH.
  - At REGEN_FRAMES - 1 the counter clears and health <= health + 1.
  - The counter clears on any hit_now, on entry to INVULN or DEAD, and on restart.
- When undefined: no regen counter exists, and health changes only via hits, restart and reset.

Test Plan:
1. Reset; Player (320,240,S=4); bullet_on with Bullet (326,240,S=4), dx=6<8 -> next edge player_hit=1 for one frame, health 3->2, invuln=1.
2. Hold the same overlap for 5 frames with bullet_on high -> exactly one player_hit pulse. Drop bullet_on for 1 frame, re-overlap after INVULN expires -> second pulse, health 2->1.
3. Bullet at (328,240,S=4), dx=8 == sum -> no pulse, health stays 3. Bullet at (327,243) -> pulse.
4. Hit at frame 0, fresh bullet overlapping at frame 10 -> player_hit pulses, health unchanged. invuln falls after exactly 60 frames. flash toggles every 8 frames while invuln=1.
5. Three damaging hits spaced 70 frames apart -> health 0, game_over=1, later overlaps give no pulse. game_restart -> health=3, game_over=0. Restart on the same edge as an overlap -> no pulse.
6. Reset_n pulsed low mid-INVULN -> outputs clear asynchronously without a clock edge. With HIT_REGEN_EN defined at health 2 and REGEN_FRAMES=300 -> health=3 after 300 frames with no hits.
